locker_ctrl: RTL and testbench

LOCKER_CTRL -- requirements
Module: locker_ctrl

---
 rtl/locker_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_locker_ctrl.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/locker_ctrl.sv
// locker_ctrl: keypad combination lock.
// Four BCD digits are entered, submitted and compared against a stored
// password. While open, a new password can be stored (enter with set_mode).
// Optional feature macro: LOCKER_LOCKOUT_EN adds the LOCKOUT state that
// freezes the keypad for LOCKOUT_CYCLES cycles after MAX_FAIL consecutive
// failed checks. Without it, failures are only counted (saturating at 3).
module locker_ctrl #(
  parameter logic [15:0] DEFAULT_PSD    = 16'h1234,
  parameter int          MAX_FAIL       = 3,
  parameter int          LOCKOUT_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       digit_valid,
  input  logic [3:0] digit,
  input  logic       enter,
  input  logic       clear,
  input  logic       set_mode,
  input  logic       lock,
  output logic       ledg,
  output logic       ledr,
  output logic       locked_out,
  output logic       pw_updated,
  output logic [1:0] fail_cnt,
  output logic [2:0] digit_cnt
);

`ifdef LOCKER_LOCKOUT_EN
  typedef enum logic [2:0] {IDLE, ENTRY, CHECK, OPEN, LOCKOUT} state_t;

  localparam int              LCW       = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
  localparam logic [LCW-1:0]  LOCK_LAST = LCW'(LOCKOUT_CYCLES - 1);

  logic [LCW-1:0] lock_cnt;
  logic [LCW-1:0] lock_cnt_nxt;
`else
  typedef enum logic [2:0] {IDLE, ENTRY, CHECK, OPEN} state_t;
`endif

  state_t      state;
  state_t      state_nxt;
  logic [15:0] entry_buf;
  logic [15:0] entry_buf_nxt;
  logic [2:0]  digit_cnt_nxt;
  logic [15:0] psd;
  logic [15:0] psd_nxt;
  logic [1:0]  fail_cnt_nxt;
  logic        pw_updated_nxt;
  logic        digit_ok;
  logic        match;
  logic [1:0]  fail_inc;

  // Saturating increment of the 2-bit failure counter.
  function automatic logic [1:0] sat_inc(input logic [1:0] v);
    return (v == 2'd3) ? 2'd3 : v + 2'd1;
  endfunction

  // A keypress is taken only for BCD values and while the buffer has room.
  assign digit_ok = digit_valid && (digit <= 4'd9) && (digit_cnt < 3'd4);
  assign match    = (digit_cnt == 3'd4) && (entry_buf == psd);
  assign fail_inc = sat_inc(fail_cnt);

  // Next-state, datapath and output decode.
  always_comb begin
    state_nxt      = state;
    entry_buf_nxt  = entry_buf;
    digit_cnt_nxt  = digit_cnt;
    psd_nxt        = psd;
    fail_cnt_nxt   = fail_cnt;
    pw_updated_nxt = 1'b0;
`ifdef LOCKER_LOCKOUT_EN
    lock_cnt_nxt   = lock_cnt;
`endif
    case (state)
      IDLE: begin
        if (enter || clear) begin
          entry_buf_nxt = '0;
          digit_cnt_nxt = '0;
        end else if (digit_ok) begin
          entry_buf_nxt = {entry_buf[11:0], digit};
          digit_cnt_nxt = digit_cnt + 3'd1;
          state_nxt     = ENTRY;
        end
      end
      ENTRY: begin
        if (clear) begin
          entry_buf_nxt = '0;
          digit_cnt_nxt = '0;
          state_nxt     = IDLE;
        end else if (enter) begin
          state_nxt = CHECK;
        end else if (digit_ok) begin
          entry_buf_nxt = {entry_buf[11:0], digit};
          digit_cnt_nxt = digit_cnt + 3'd1;
        end
      end
      CHECK: begin
        entry_buf_nxt = '0;
        digit_cnt_nxt = '0;
        if (match) begin
          fail_cnt_nxt = '0;
          state_nxt    = OPEN;
        end else begin
          fail_cnt_nxt = fail_inc;
          state_nxt    = IDLE;
`ifdef LOCKER_LOCKOUT_EN
          if (int'(fail_inc) >= MAX_FAIL) begin
            state_nxt    = LOCKOUT;
            lock_cnt_nxt = '0;
          end
`endif
        end
      end
      OPEN: begin
        if (lock) begin
          entry_buf_nxt = '0;
          digit_cnt_nxt = '0;
          state_nxt     = IDLE;
        end else if (clear) begin
          entry_buf_nxt = '0;
          digit_cnt_nxt = '0;
        end else if (enter) begin
          if (set_mode && (digit_cnt == 3'd4)) begin
            psd_nxt        = entry_buf;
            pw_updated_nxt = 1'b1;
          end
          entry_buf_nxt = '0;
          digit_cnt_nxt = '0;
        end else if (digit_ok) begin
          entry_buf_nxt = {entry_buf[11:0], digit};
          digit_cnt_nxt = digit_cnt + 3'd1;
        end
      end
`ifdef LOCKER_LOCKOUT_EN
      LOCKOUT: begin
        if (lock_cnt == LOCK_LAST) begin
          lock_cnt_nxt = '0;
          fail_cnt_nxt = '0;
          state_nxt    = IDLE;
        end else begin
          lock_cnt_nxt = lock_cnt + LCW'(1);
        end
      end
`endif
      default: begin
        entry_buf_nxt = '0;
        digit_cnt_nxt = '0;
        state_nxt     = IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      entry_buf  <= '0;
      digit_cnt  <= '0;
      psd        <= DEFAULT_PSD;
      fail_cnt   <= '0;
      ledg       <= 1'b0;
      ledr       <= 1'b1;
      pw_updated <= 1'b0;
    end else begin
      state      <= state_nxt;
      entry_buf  <= entry_buf_nxt;
      digit_cnt  <= digit_cnt_nxt;
      psd        <= psd_nxt;
      fail_cnt   <= fail_cnt_nxt;
      ledg       <= (state_nxt == OPEN);
      ledr       <= (state_nxt != OPEN);
      pw_updated <= pw_updated_nxt;
    end
  end

`ifdef LOCKER_LOCKOUT_EN
  // Lockout timer and its registered indicator.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_cnt   <= '0;
      locked_out <= 1'b0;
    end else begin
      lock_cnt   <= lock_cnt_nxt;
      locked_out <= (state_nxt == LOCKOUT);
    end
  end
`else
  assign locked_out = 1'b0;
`endif

endmodule

// File: tb/tb_locker_ctrl.sv
// tb_locker_ctrl: self-checking bench for locker_ctrl with a code-level
// reference model (stored password, consecutive failures, open/locked).
// Honors LOCKER_LOCKOUT_EN the same way the design does.
module tb_locker_ctrl;
  localparam logic [15:0] DEF_PSD = 16'h1234;
  localparam int          LOCK_N  = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic       digit_valid;
  logic [3:0] digit;
  logic       enter;
  logic       clear;
  logic       set_mode;
  logic       lock;
  logic       ledg;
  logic       ledr;
  logic       locked_out;
  logic       pw_updated;
  logic [1:0] fail_cnt;
  logic [2:0] digit_cnt;

  int checks   = 0;
  int failures = 0;

  // Reference model: the lock seen as codes and outcomes.
  logic [15:0] m_psd;
  int          m_fail;

  always #5 clk = ~clk;

  locker_ctrl #(
    .DEFAULT_PSD   (DEF_PSD),
    .MAX_FAIL      (3),
    .LOCKOUT_CYCLES(LOCK_N)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .digit_valid(digit_valid),
    .digit      (digit),
    .enter      (enter),
    .clear      (clear),
    .set_mode   (set_mode),
    .lock       (lock),
    .ledg       (ledg),
    .ledr       (ledr),
    .locked_out (locked_out),
    .pw_updated (pw_updated),
    .fail_cnt   (fail_cnt),
    .digit_cnt  (digit_cnt)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    digit_valid = 1'b0;
    digit       = 4'd0;
    enter       = 1'b0;
    clear       = 1'b0;
    set_mode    = 1'b0;
    lock        = 1'b0;
  endtask

  task automatic press(input logic [3:0] d);
    digit_valid = 1'b1;
    digit       = d;
    tick();
    digit_valid = 1'b0;
    digit       = 4'd0;
  endtask

  task automatic press_enter(input logic sm);
    enter    = 1'b1;
    set_mode = sm;
    tick();
    enter    = 1'b0;
    set_mode = 1'b0;
  endtask

  task automatic press_lock();
    lock = 1'b1;
    tick();
    lock = 1'b0;
  endtask

  task automatic type_code(input logic [15:0] c);
    for (int i = 3; i >= 0; i--) press(c[i*4 +: 4]);
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    #1;
    checks++; if (ledg !== 1'b0) begin failures++; $display("FAIL reset_ledg: got %b want 0", ledg); end
    checks++; if (ledr !== 1'b1) begin failures++; $display("FAIL reset_ledr: got %b want 1", ledr); end
    checks++; if (locked_out !== 1'b0) begin failures++; $display("FAIL reset_locked_out: got %b want 0", locked_out); end
    checks++; if (pw_updated !== 1'b0) begin failures++; $display("FAIL reset_pw_updated: got %b want 0", pw_updated); end
    checks++; if (fail_cnt !== 2'd0) begin failures++; $display("FAIL reset_fail_cnt: got %0d want 0", fail_cnt); end
    checks++; if (digit_cnt !== 3'd0) begin failures++; $display("FAIL reset_digit_cnt: got %0d want 0", digit_cnt); end
    tick();
    tick();
    rst = 1'b0;
    tick();
    m_psd  = DEF_PSD;
    m_fail = 0;
  endtask

  task automatic test_open_basic();
    type_code(16'h1234);
    checks++; if (digit_cnt !== 3'd4) begin failures++; $display("FAIL basic_digit_cnt: got %0d want 4", digit_cnt); end
    press_enter(1'b0);
    checks++; if (ledg !== 1'b0) begin failures++; $display("FAIL basic_ledg_early: got %b want 0", ledg); end
    tick();
    checks++; if (ledg !== 1'b1) begin failures++; $display("FAIL basic_ledg: got %b want 1", ledg); end
    checks++; if (ledr !== 1'b0) begin failures++; $display("FAIL basic_ledr: got %b want 0", ledr); end
    checks++; if (fail_cnt !== 2'd0) begin failures++; $display("FAIL basic_fail_cnt: got %0d want 0", fail_cnt); end
    press_lock();
    checks++; if (ledg !== 1'b0 || ledr !== 1'b1) begin failures++; $display("FAIL basic_relock: got ledg=%b ledr=%b want 0/1", ledg, ledr); end
  endtask

  task automatic test_short_and_extra();
    press(4'd1); press(4'd2); press(4'd3);
    press_enter(1'b0);
    tick();
    m_fail = 1;
    checks++; if (ledg !== 1'b0) begin failures++; $display("FAIL short_ledg: got %b want 0", ledg); end
    checks++; if (fail_cnt !== 2'd1) begin failures++; $display("FAIL short_fail_cnt: got %0d want 1", fail_cnt); end
    for (int d = 1; d <= 5; d++) press(4'(d));
    checks++; if (digit_cnt !== 3'd4) begin failures++; $display("FAIL extra_digit_cnt: got %0d want 4", digit_cnt); end
    press_enter(1'b0);
    tick();
    m_fail = 0;
    checks++; if (ledg !== 1'b1) begin failures++; $display("FAIL extra_ledg: got %b want 1", ledg); end
    checks++; if (fail_cnt !== 2'd0) begin failures++; $display("FAIL extra_fail_cnt: got %0d want 0", fail_cnt); end
    press_lock();
  endtask

  task automatic test_pw_change();
    type_code(m_psd);
    press_enter(1'b0);
    tick();
    type_code(16'h9876);
    press_enter(1'b1);
    m_psd = 16'h9876;
    checks++; if (pw_updated !== 1'b1) begin failures++; $display("FAIL pw_pulse: got %b want 1", pw_updated); end
    tick();
    checks++; if (pw_updated !== 1'b0) begin failures++; $display("FAIL pw_pulse_len: got %b want 0", pw_updated); end
    checks++; if (ledg !== 1'b1) begin failures++; $display("FAIL pw_stay_open: got %b want 1", ledg); end
    press_lock();
    type_code(16'h1234);
    press_enter(1'b0);
    tick();
    checks++; if (ledg !== 1'b0 || fail_cnt !== 2'd1) begin failures++; $display("FAIL pw_old_code: got ledg=%b fail=%0d want 0/1", ledg, fail_cnt); end
    type_code(16'h9876);
    press_enter(1'b0);
    tick();
    checks++; if (ledg !== 1'b1 || fail_cnt !== 2'd0) begin failures++; $display("FAIL pw_new_code: got ledg=%b fail=%0d want 1/0", ledg, fail_cnt); end
    m_fail = 0;
    press_lock();
  endtask

  task automatic test_clear_enter();
    type_code(16'h0000);
    press_enter(1'b0);
    tick();
    m_fail = 1;
    press(4'd1); press(4'd2);
    clear = 1'b1;
    enter = 1'b1;
    tick();
    clear = 1'b0;
    enter = 1'b0;
    tick();
    checks++; if (digit_cnt !== 3'd0) begin failures++; $display("FAIL clr_digit_cnt: got %0d want 0", digit_cnt); end
    checks++; if (fail_cnt !== 2'(m_fail)) begin failures++; $display("FAIL clr_fail_cnt: got %0d want %0d", fail_cnt, m_fail); end
    checks++; if (ledg !== 1'b0) begin failures++; $display("FAIL clr_ledg: got %b want 0", ledg); end
    press_enter(1'b0);
    tick();
    checks++; if (fail_cnt !== 2'(m_fail)) begin failures++; $display("FAIL idle_enter_fail_cnt: got %0d want %0d", fail_cnt, m_fail); end
    type_code(m_psd);
    press_enter(1'b0);
    tick();
    m_fail = 0;
    checks++; if (ledg !== 1'b1) begin failures++; $display("FAIL clr_then_open: got %b want 1", ledg); end
    press_lock();
  endtask

`ifdef LOCKER_LOCKOUT_EN
  task automatic test_lockout();
    for (int k = 0; k < 3; k++) begin
      type_code(m_psd ^ 16'h0001);
      press_enter(1'b0);
      tick();
    end
    checks++; if (locked_out !== 1'b1) begin failures++; $display("FAIL lo_enter: got %b want 1", locked_out); end
    checks++; if (fail_cnt !== 2'd3) begin failures++; $display("FAIL lo_fail_cnt: got %0d want 3", fail_cnt); end
    type_code(m_psd);
    press_enter(1'b0);
    checks++; if (digit_cnt !== 3'd0 || ledg !== 1'b0) begin failures++; $display("FAIL lo_ignore: got cnt=%0d ledg=%b want 0/0", digit_cnt, ledg); end
    for (int k = 0; k < 4; k++) tick();
    checks++; if (locked_out !== 1'b1) begin failures++; $display("FAIL lo_length: got %b want 1", locked_out); end
    tick();
    checks++; if (locked_out !== 1'b0 || fail_cnt !== 2'd0) begin failures++; $display("FAIL lo_exit: got lo=%b fail=%0d want 0/0", locked_out, fail_cnt); end
    m_fail = 0;
    type_code(m_psd);
    press_enter(1'b0);
    tick();
    checks++; if (ledg !== 1'b1) begin failures++; $display("FAIL lo_after_open: got %b want 1", ledg); end
    press_lock();
  endtask
`else
  task automatic test_fail_saturate();
    for (int k = 0; k < 5; k++) begin
      type_code(m_psd ^ 16'h0100);
      press_enter(1'b0);
      tick();
    end
    m_fail = 3;
    checks++; if (fail_cnt !== 2'd3) begin failures++; $display("FAIL sat_fail_cnt: got %0d want 3", fail_cnt); end
    checks++; if (locked_out !== 1'b0) begin failures++; $display("FAIL sat_locked_out: got %b want 0", locked_out); end
    type_code(m_psd);
    press_enter(1'b0);
    tick();
    m_fail = 0;
    checks++; if (ledg !== 1'b1 || fail_cnt !== 2'd0) begin failures++; $display("FAIL sat_open: got ledg=%b fail=%0d want 1/0", ledg, fail_cnt); end
    press_lock();
  endtask
`endif

  task automatic test_reset_midway();
    type_code(m_psd);
    press_enter(1'b0);
    tick();
    type_code(16'h5555);
    press_enter(1'b1);
    press_lock();
`ifdef LOCKER_LOCKOUT_EN
    for (int k = 0; k < 3; k++) begin
      type_code(16'h0000);
      press_enter(1'b0);
      tick();
    end
    checks++; if (locked_out !== 1'b1) begin failures++; $display("FAIL rst_pre_lock: got %b want 1", locked_out); end
`else
    press(4'd1); press(4'd2);
`endif
    #3;
    rst = 1'b1;
    #1;
    checks++; if (locked_out !== 1'b0 || digit_cnt !== 3'd0 || fail_cnt !== 2'd0) begin
      failures++; $display("FAIL rst_async: got lo=%b cnt=%0d fail=%0d want 0/0/0", locked_out, digit_cnt, fail_cnt);
    end
    tick();
    rst = 1'b0;
    tick();
    m_psd  = DEF_PSD;
    m_fail = 0;
    type_code(16'h1234);
    press_enter(1'b0);
    tick();
    checks++; if (ledg !== 1'b1) begin failures++; $display("FAIL rst_default_psd: got %b want 1", ledg); end
    press_lock();
  endtask

  task automatic test_random();
    for (int it = 0; it < 40; it++) begin
      int          n;
      int          mode;
      int          vcount;
      logic [15:0] code;
      logic [3:0]  keys[$];
      logic [3:0]  k;
      keys.delete();
      mode = $urandom_range(0, 2);
      if (mode == 1) begin
        n = $urandom_range(0, 6);
        for (int i = 0; i < n; i++) keys.push_back(4'($urandom_range(0, 15)));
      end else begin
        for (int i = 3; i >= 0; i--) keys.push_back(m_psd[i*4 +: 4]);
        if (mode == 2) keys.insert($urandom_range(0, 4), 4'($urandom_range(10, 15)));
        else if ($urandom_range(0, 1) == 1) keys.push_back(4'($urandom_range(0, 9)));
      end
      vcount = 0;
      code   = '0;
      foreach (keys[i]) begin
        k = keys[i];
        press(k);
        if (k <= 4'd9 && vcount < 4) begin
          code   = {code[11:0], k};
          vcount = vcount + 1;
        end
        checks++; if (digit_cnt !== 3'(vcount)) begin failures++; $display("FAIL rnd_digit_cnt it=%0d: got %0d want %0d", it, digit_cnt, vcount); end
      end
      press_enter(1'b0);
      tick();
      if (vcount == 0) begin
        checks++; if (ledg !== 1'b0 || fail_cnt !== 2'(m_fail)) begin
          failures++; $display("FAIL rnd_idle_enter it=%0d: got ledg=%b fail=%0d want 0/%0d", it, ledg, fail_cnt, m_fail);
        end
      end else if (vcount == 4 && code == m_psd) begin
        m_fail = 0;
        checks++; if (ledg !== 1'b1 || fail_cnt !== 2'd0) begin
          failures++; $display("FAIL rnd_open it=%0d: got ledg=%b fail=%0d want 1/0", it, ledg, fail_cnt);
        end
        mode = $urandom_range(0, 2);
        if (mode == 0) begin
          code = '0;
          for (int i = 0; i < 4; i++) code = {code[11:0], 4'($urandom_range(0, 9))};
          type_code(code);
          press_enter(1'b1);
          m_psd = code;
          checks++; if (pw_updated !== 1'b1) begin failures++; $display("FAIL rnd_pw_set it=%0d: got %b want 1", it, pw_updated); end
        end else if (mode == 1) begin
          press(4'd7); press(4'd7); press(4'd7);
          press_enter(1'b1);
          checks++; if (pw_updated !== 1'b0) begin failures++; $display("FAIL rnd_pw_short it=%0d: got %b want 0", it, pw_updated); end
        end
        press_lock();
        checks++; if (ledg !== 1'b0) begin failures++; $display("FAIL rnd_lock it=%0d: got %b want 0", it, ledg); end
      end else begin
        m_fail = (m_fail >= 3) ? 3 : m_fail + 1;
        checks++; if (ledg !== 1'b0 || fail_cnt !== 2'(m_fail)) begin
          failures++; $display("FAIL rnd_reject it=%0d: got ledg=%b fail=%0d want 0/%0d", it, ledg, fail_cnt, m_fail);
        end
`ifdef LOCKER_LOCKOUT_EN
        if (m_fail >= 3) begin
          checks++; if (locked_out !== 1'b1) begin failures++; $display("FAIL rnd_lockout it=%0d: got %b want 1", it, locked_out); end
          for (int i = 0; i < LOCK_N; i++) tick();
          m_fail = 0;
          checks++; if (locked_out !== 1'b0 || fail_cnt !== 2'd0) begin
            failures++; $display("FAIL rnd_unlock it=%0d: got lo=%b fail=%0d want 0/0", it, locked_out, fail_cnt);
          end
        end
`else
        checks++; if (locked_out !== 1'b0) begin failures++; $display("FAIL rnd_no_lockout it=%0d: got %b want 0", it, locked_out); end
`endif
      end
    end
  endtask

  initial begin
    test_reset();
    test_open_basic();
    test_short_and_extra();
    test_pw_change();
    test_clear_enter();
`ifdef LOCKER_LOCKOUT_EN
    test_lockout();
`else
    test_fail_saturate();
`endif
    test_reset_midway();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
